// File: rtl/riscv_mem_lsu_if.sv
// Bundle of pipeline-facing and data-memory signals for the memory-stage LSU.
// The LSU side takes the master modport; the pipeline/memory environment takes slave.
interface riscv_mem_lsu_if;
    logic        i_riscv_lsu_memr_m;
    logic        i_riscv_lsu_memw_m;
    logic [63:0] i_riscv_lsu_addr_m;
    logic [63:0] i_riscv_lsu_storedata_m;
    logic [1:0]  i_riscv_lsu_storesrc_m;
    logic [2:0]  i_riscv_lsu_memext_m;
    logic        i_riscv_lsu_dmem_ack;
    logic [63:0] i_riscv_lsu_dmem_rdata;
    logic        o_riscv_lsu_dmem_req;
    logic        o_riscv_lsu_dmem_we;
    logic [63:0] o_riscv_lsu_dmem_addr;
    logic [63:0] o_riscv_lsu_dmem_wdata;
    logic [7:0]  o_riscv_lsu_dmem_wstrb;
    logic [63:0] o_riscv_lsu_loaddata_m;
    logic        o_riscv_lsu_stall;
    logic        o_riscv_lsu_misaligned;

    modport master (
        input  i_riscv_lsu_memr_m, i_riscv_lsu_memw_m, i_riscv_lsu_addr_m,
               i_riscv_lsu_storedata_m, i_riscv_lsu_storesrc_m, i_riscv_lsu_memext_m,
               i_riscv_lsu_dmem_ack, i_riscv_lsu_dmem_rdata,
        output o_riscv_lsu_dmem_req, o_riscv_lsu_dmem_we, o_riscv_lsu_dmem_addr,
               o_riscv_lsu_dmem_wdata, o_riscv_lsu_dmem_wstrb, o_riscv_lsu_loaddata_m,
               o_riscv_lsu_stall, o_riscv_lsu_misaligned
    );

    modport slave (
        output i_riscv_lsu_memr_m, i_riscv_lsu_memw_m, i_riscv_lsu_addr_m,
               i_riscv_lsu_storedata_m, i_riscv_lsu_storesrc_m, i_riscv_lsu_memext_m,
               i_riscv_lsu_dmem_ack, i_riscv_lsu_dmem_rdata,
        input  o_riscv_lsu_dmem_req, o_riscv_lsu_dmem_we, o_riscv_lsu_dmem_addr,
               o_riscv_lsu_dmem_wdata, o_riscv_lsu_dmem_wstrb, o_riscv_lsu_loaddata_m,
               o_riscv_lsu_stall, o_riscv_lsu_misaligned
    );
endinterface

// File: rtl/riscv_mem_lsu.sv
// Memory-stage load/store unit: one req/ack transaction per load or store,
// store lane alignment, load extraction/extension, and pipeline stall.
module riscv_mem_lsu (
    input  logic           i_riscv_lsu_clk,
    input  logic           i_riscv_lsu_rst,
    riscv_mem_lsu_if.master lsu
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t      state;
    logic [2:0]  lat_off;
    logic [2:0]  lat_ext;

    logic        op;
    logic        is_store;
    logic [1:0]  size_code;
    logic        misal_raw;
    logic [2:0]  off;
    logic [63:0] align_wdata;
    logic [7:0]  align_wstrb;
    logic [63:0] shifted;
    logic [63:0] extended;

    assign op       = lsu.i_riscv_lsu_memr_m | lsu.i_riscv_lsu_memw_m;
    assign is_store = lsu.i_riscv_lsu_memw_m;
    assign off      = lsu.i_riscv_lsu_addr_m[2:0];

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        size_code = 2'd3;
        if (is_store)
            size_code = lsu.i_riscv_lsu_storesrc_m;
        else if (lsu.i_riscv_lsu_memext_m != 3'b111)
            size_code = lsu.i_riscv_lsu_memext_m[1:0];

        misal_raw = 1'b0;
        case (size_code)
            2'd1:    misal_raw = off[0];
            2'd2:    misal_raw = |off[1:0];
            2'd3:    misal_raw = |off;
            default: misal_raw = 1'b0;
        endcase
    end

    always_comb begin
        align_wdata = lsu.i_riscv_lsu_storedata_m;
        align_wstrb = 8'hFF;
        case (lsu.i_riscv_lsu_storesrc_m)
            2'b00: begin
                align_wdata = {8{lsu.i_riscv_lsu_storedata_m[7:0]}};
                align_wstrb = 8'h01 << off;
            end
            2'b01: begin
                align_wdata = {4{lsu.i_riscv_lsu_storedata_m[15:0]}};
                align_wstrb = 8'h03 << off;
            end
            2'b10: begin
                align_wdata = {2{lsu.i_riscv_lsu_storedata_m[31:0]}};
                align_wstrb = 8'h0F << off;
            end
            default: begin
                align_wdata = lsu.i_riscv_lsu_storedata_m;
                align_wstrb = 8'hFF;
            end
        endcase
    end

    // Load extraction always works from the latched offset/type, never the live inputs.
    always_comb begin
        shifted  = lsu.i_riscv_lsu_dmem_rdata >> {lat_off, 3'b000};
        extended = shifted;
        case (lat_ext)
            3'b000:  extended = {{56{shifted[7]}},  shifted[7:0]};
            3'b001:  extended = {{48{shifted[15]}}, shifted[15:0]};
            3'b010:  extended = {{32{shifted[31]}}, shifted[31:0]};
            3'b100:  extended = {56'd0, shifted[7:0]};
            3'b101:  extended = {48'd0, shifted[15:0]};
            3'b110:  extended = {32'd0, shifted[31:0]};
            default: extended = shifted;
        endcase
    end

    assign lsu.o_riscv_lsu_misaligned = (state == S_IDLE) && op && misal_raw;
    assign lsu.o_riscv_lsu_stall      = ((state == S_IDLE) && op && !misal_raw) ||
                                        ((state == S_WAIT) && !lsu.i_riscv_lsu_dmem_ack);
    assign lsu.o_riscv_lsu_loaddata_m = ((state == S_WAIT) && lsu.i_riscv_lsu_dmem_ack &&
                                         !lsu.o_riscv_lsu_dmem_we) ? extended : 64'd0;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge i_riscv_lsu_clk or posedge i_riscv_lsu_rst) begin
        if (i_riscv_lsu_rst) begin
            state                    <= S_IDLE;
            lsu.o_riscv_lsu_dmem_req   <= 1'b0;
            lsu.o_riscv_lsu_dmem_we    <= 1'b0;
            lsu.o_riscv_lsu_dmem_addr  <= 64'd0;
            lsu.o_riscv_lsu_dmem_wdata <= 64'd0;
            lsu.o_riscv_lsu_dmem_wstrb <= 8'd0;
            lat_off                  <= 3'd0;
            lat_ext                  <= 3'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (op && !misal_raw) begin
                        state                    <= S_WAIT;
                        lsu.o_riscv_lsu_dmem_req   <= 1'b1;
                        lsu.o_riscv_lsu_dmem_we    <= is_store;
                        lsu.o_riscv_lsu_dmem_addr  <= {lsu.i_riscv_lsu_addr_m[63:3], 3'b000};
                        lsu.o_riscv_lsu_dmem_wdata <= is_store ? align_wdata : 64'd0;
                        lsu.o_riscv_lsu_dmem_wstrb <= is_store ? align_wstrb : 8'd0;
                        lat_off                  <= off;
                        lat_ext                  <= lsu.i_riscv_lsu_memext_m;
                    end
                end
                S_WAIT: begin
                    if (lsu.i_riscv_lsu_dmem_ack) begin
                        state                    <= S_IDLE;
                        lsu.o_riscv_lsu_dmem_req   <= 1'b0;
                        lsu.o_riscv_lsu_dmem_we    <= 1'b0;
                        lsu.o_riscv_lsu_dmem_addr  <= 64'd0;
                        lsu.o_riscv_lsu_dmem_wdata <= 64'd0;
                        lsu.o_riscv_lsu_dmem_wstrb <= 8'd0;
                        lat_off                  <= 3'd0;
                        lat_ext                  <= 3'd0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/riscv_mem_lsu.md
# riscv_mem_lsu

Memory-stage load/store unit for the RISC-V core, directly downstream of the execute/memory pipeline register. It takes the registered memory-stage controls and operands, issues one request per load or store to the data memory over a req/ack handshake, and aligns store data into byte lanes. It extracts and sign- or zero-extends load data. While a request is outstanding it stalls the pipeline, so the memory/writeback register captures load data in the cycle the access completes.

## Interface
Parameters: none. The data path is fixed at 64 bits.

- i_riscv_lsu_clk  in  1  clock; all state updates on the rising edge
- i_riscv_lsu_rst  in  1  reset; asynchronous, active-high
- i_riscv_lsu_memr_m  in  1  load request from the EM register
- i_riscv_lsu_memw_m  in  1  store request from the EM register
- i_riscv_lsu_addr_m  in  64  effective address (ALU result)
- i_riscv_lsu_storedata_m  in  64  store operand, right-justified
- i_riscv_lsu_storesrc_m  in  2  store size: 00 SB, 01 SH, 10 SW, 11 SD
- i_riscv_lsu_memext_m  in  3  load type: 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU; 111 behaves as LD
- i_riscv_lsu_dmem_ack  in  1  memory completes the current request
- i_riscv_lsu_dmem_rdata  in  64  read data for the doubleword at dmem_addr
- o_riscv_lsu_dmem_req  out  1  request valid, registered
- o_riscv_lsu_dmem_we  out  1  1 for a store, registered
- o_riscv_lsu_dmem_addr  out  64  doubleword address, addr & ~7, registered
- o_riscv_lsu_dmem_wdata  out  64  lane-aligned store data, registered
- o_riscv_lsu_dmem_wstrb  out  8  byte enables, registered
- o_riscv_lsu_loaddata_m  out  64  extended load result, combinational
- o_riscv_lsu_stall  out  1  freezes the upstream pipeline, combinational
- o_riscv_lsu_misaligned  out  1  misaligned-access flag, combinational

## Operation
- An "op" is present when memr or memw is 1. If both are 1, the store wins and the load is ignored.
- Misaligned conditions:
  - half access with addr[0] != 0
  - word access with addr[1:0] != 0
  - double access with addr[2:0] != 0
- FSM states:
  - IDLE: no request outstanding.
  - WAIT: request outstanding.
- IDLE, aligned op present:
  - stall = 1.
  - At the next edge, go to WAIT and latch addr[2:0], memext, we, dmem_addr, wdata and wstrb.
  - req becomes 1.
- IDLE, misaligned op present:
  - misaligned = 1 and stall = 0.
  - No request is issued; loaddata = 0.
  - Stay in IDLE.
- WAIT:
  - req and all latched fields stay stable until ack.
  - stall = !ack.
  - On ack, go to IDLE at the next edge; req = 0 and the latched fields are cleared to 0.
- ack received in IDLE is ignored.
- Store lane alignment, with o = addr[2:0]:
  - SB: wdata = byte replicated ×8; wstrb = 8'h01 << o.
  - SH: wdata = half replicated ×4; wstrb = 8'h03 << o.
  - SW: wdata = word replicated ×2; wstrb = 8'h0F << o.
  - SD: wdata = data; wstrb = 8'hFF.
- Load path:
  - loaddata = extend(rdata >> (8 × latched o)) according to the latched memext.
  - Driven only while in WAIT with ack = 1; 0 otherwise.
- For stores, loaddata is 0.

## Timing
- Reset (async, takes effect immediately):
  - state = IDLE.
  - req, we, dmem_addr, wdata and wstrb = 0.
  - stall, misaligned and loaddata = 0, given no op is present.
- Minimum access:
  - Op presented in cycle 0 → req = 1 in cycle 1.
  - If ack = 1 in cycle 1: stall = 1 in cycle 0 only, and loaddata is valid in cycle 1.
  - The upstream EM register advances at the end of cycle 1.
- With ack in cycle 1+N, stall is high for cycles 0..N.
- Back-to-back ops: the next op is seen in IDLE in the cycle after ack. Request throughput is at most one every 2 cycles.
- Reset asserted in WAIT: req drops asynchronously, a pending ack is discarded, and the FSM returns to IDLE.
- Upstream holds op, addr and data stable while stall = 1. The LSU still uses only its latched copies during WAIT.

## Test plan
- Reset → all outputs 0. An ack pulse while in IDLE causes no change.
- LB, addr 0x1003, ack in cycle 1, rdata 0x0000_0000_8000_0000:
  - dmem_addr = 0x1000, we = 0.
  - stall = 1 in cycle 0 only.
  - loaddata = 0xFFFF_FFFF_FFFF_FF80 in cycle 1.
- SH, addr 0x2006, storedata 0x1234:
  - dmem_addr = 0x2000, wstrb = 0xC0, we = 1.
  - wdata[63:48] = 0x1234.
  - loaddata = 0.
- LW, addr 0x1002 → misaligned = 1, stall = 0, req never asserted, loaddata = 0.
- LWU, addr 0x3004, ack delayed to cycle 4, rdata 0xDEAD_BEEF_0000_0000:
  - stall = 1 in cycles 0..3.
  - req and dmem_addr = 0x3000 stable through cycle 4.
  - loaddata = 0x0000_0000_DEAD_BEEF in cycle 4.
- Reset pulsed in cycle 2 of a pending SD:
  - req = 0 immediately.
  - A later ack is ignored and the FSM stays in IDLE.
